// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding IMEM requests and feeds decode.
// Optional macro FE_JAL_REDIRECT_EN: JAL is redirected inside fetch instead of waiting for execute.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_DATA,
    input  logic        stall,
    input  logic        V_DE_FE_BR_STALL,
    input  logic        BR_RESOLVE_V,
    input  logic        BR_TAKEN,
    input  logic [63:0] BR_TARGET,
    output logic [31:0] DE_IR,
    output logic [63:0] DE_NPC,
    output logic        DE_V
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_BR_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] buf_ir_q, buf_ir_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [31:0] de_ir_q, de_ir_d;
    logic [63:0] de_npc_q, de_npc_d;
    logic        de_v_q, de_v_d;

    logic        complete;
    logic        avail;
    logic        deliver;
    logic        is_ctrl;
    logic [31:0] word;
    logic [63:0] word_pc;

    assign IMEM_REQ  = (state_q == S_FETCH) && !RESET;
    assign IMEM_ADDR = pc_q;

    assign complete = (state_q == S_FETCH) && IMEM_RDY;
    assign avail    = (state_q == S_HOLD) || complete;
    assign word     = (state_q == S_HOLD) ? buf_ir_q : IMEM_DATA;
    assign word_pc  = (state_q == S_HOLD) ? buf_pc_q : pc_q;
    assign deliver  = avail && !stall && !V_DE_FE_BR_STALL;
    assign is_ctrl  = (word[6:2] == 5'b11000) || (word[6:2] == 5'b11001) ||
                      (word[6:2] == 5'b11011);

`ifdef FE_JAL_REDIRECT_EN
    logic        is_jal;
    logic [63:0] jal_target;

    assign is_jal     = (word[6:2] == 5'b11011);
    assign jal_target = word_pc + {{44{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        buf_ir_d = buf_ir_q;
        buf_pc_d = buf_pc_q;
        de_ir_d  = de_ir_q;
        de_npc_d = de_npc_q;
        de_v_d   = de_v_q;

        if (!stall) begin
            de_v_d = deliver;
            if (deliver) begin
                de_ir_d  = word;
                de_npc_d = word_pc;
            end
        end

        case (state_q)
            S_FETCH: begin
                if (complete) begin
                    pc_d = pc_q + 64'd4;
                    if (!deliver) begin
                        buf_ir_d = word;
                        buf_pc_d = pc_q;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_BR_WAIT: begin
                if (BR_RESOLVE_V) begin
                    if (BR_TAKEN) begin
                        pc_d = BR_TARGET & ~64'h3;
                    end
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase

        // A delivery can only come from FETCH-with-completion or HOLD; it decides the next state.
        if (deliver) begin
            state_d = is_ctrl ? S_BR_WAIT : S_FETCH;
`ifdef FE_JAL_REDIRECT_EN
            if (is_jal) begin
                state_d = S_FETCH;
                pc_d    = jal_target & ~64'h3;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC & ~64'h3;
            de_v_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            de_v_q  <= de_v_d;
        end
    end

    // NOTE: data-only registers carry no reset; their validity is tracked by state_q and de_v_q.
    always_ff @(posedge CLK) begin
        buf_ir_q <= buf_ir_d;
        buf_pc_q <= buf_pc_d;
        de_ir_q  <= de_ir_d;
        de_npc_q <= de_npc_d;
    end

    assign DE_IR  = de_ir_q;
    assign DE_NPC = de_npc_q;
    assign DE_V   = de_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written control-transfer and
// reset sequences, then randomized traffic checked against a program-order fetch model.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BEQ    = 32'h0000_0063;
    localparam logic [31:0] JALR   = 32'h0000_8067;
    localparam logic [31:0] JAL100 = 32'h1000_006F;  // jal x0, +0x100

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_data = '0;
    logic        stall = 1'b0;
    logic        br_stall = 1'b0;
    logic        br_rv = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [31:0] de_ir;
    logic [63:0] de_npc;
    logic        de_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .IMEM_REQ         (imem_req),
        .IMEM_ADDR        (imem_addr),
        .IMEM_RDY         (imem_rdy),
        .IMEM_DATA        (imem_data),
        .stall            (stall),
        .V_DE_FE_BR_STALL (br_stall),
        .BR_RESOLVE_V     (br_rv),
        .BR_TAKEN         (br_taken),
        .BR_TARGET        (br_target),
        .DE_IR            (de_ir),
        .DE_NPC           (de_npc),
        .DE_V             (de_v)
    );

    logic [31:0] prog [logic [63:0]];
    logic [31:0] rnd_mem [256];
    bit          use_rnd = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (use_rnd) return rnd_mem[a[9:2]];
        if (prog.exists(a)) return prog[a];
        return NOP;
    endfunction

    function automatic bit is_ctrl(input logic [31:0] w);
        return w[6:2] inside {5'b11000, 5'b11001, 5'b11011};
    endfunction

    function automatic logic [63:0] jimm(input logic [31:0] w);
        return {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply this cycle's inputs (memory answers for the current IMEM_ADDR) and let them settle.
    task automatic drive(input bit rdy, input bit stl, input bit brs, input bit rv, input bit tk,
                         input logic [63:0] tgt);
        imem_rdy  = rdy;
        stall     = stl;
        br_stall  = brs;
        br_rv     = rv;
        br_taken  = tk;
        br_target = tgt;
        imem_data = mem_word(imem_addr);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        check("reset_req", imem_req, 1'b0);
        tick;
        rst = 1'b0;
    endtask

    task automatic chk_fetch(input string name, input bit req, input logic [63:0] addr);
        check({name, "_req"}, imem_req, req);
        if (req) check({name, "_addr"}, imem_addr, addr);
    endtask

    typedef struct {
        bit          rdy;
        bit          stl;
        bit          req;
        logic [63:0] addr;
        bit          dv;
        logic [63:0] npc;
    } vec_t;

    vec_t vt [12];

    task automatic run_table;
        vt[0]  = '{1'b1, 1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 64'h1008, 1'b1, 64'h1004};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 64'h100c, 1'b1, 64'h1008};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 64'h1010, 1'b1, 64'h100c};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 64'h1014, 1'b1, 64'h100c};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 64'h1014, 1'b1, 64'h100c};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 64'h1014, 1'b1, 64'h100c};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 64'h1014, 1'b1, 64'h1010};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 64'h1018, 1'b1, 64'h1014};
        vt[10] = '{1'b1, 1'b0, 1'b1, 64'h1018, 1'b0, 64'h0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 64'h101c, 1'b1, 64'h1018};
        do_reset;
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].rdy, vt[i].stl, 1'b0, 1'b0, 1'b0, 64'h0);
            check($sformatf("tbl%0d_req", i), imem_req, vt[i].req);
            check($sformatf("tbl%0d_addr", i), imem_addr, vt[i].addr);
            check($sformatf("tbl%0d_dev", i), de_v, vt[i].dv);
            if (vt[i].dv) begin
                check($sformatf("tbl%0d_npc", i), de_npc, vt[i].npc);
                check($sformatf("tbl%0d_ir", i), de_ir, NOP);
            end
            tick;
        end
    endtask

    task automatic run_branches;
        prog[64'h1000] = JALR;
        prog[64'h2000] = BEQ;
        prog[64'h2040] = BEQ;
        prog[64'h2044] = JALR;
        prog[64'h3000] = JAL100;
        do_reset;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("jalr_fetch", 1, 64'h1000); tick;
        drive(1, 0, 1, 0, 0, 64'h0);  chk_fetch("jalr_wait", 0, 0);
        check("jalr_dev", de_v, 1'b1); check("jalr_ir", de_ir, JALR); tick;
        drive(1, 0, 1, 0, 0, 64'h0);  chk_fetch("jalr_wait2", 0, 0);
        check("jalr_bubble", de_v, 1'b0); tick;
        drive(1, 0, 1, 1, 1, 64'h2002); chk_fetch("jalr_resolve", 0, 0); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("taken_fetch", 1, 64'h2000); tick;
        drive(1, 0, 1, 0, 0, 64'h0);  chk_fetch("beq_wait", 0, 0);
        check("beq_npc", de_npc, 64'h2000); tick;
        drive(1, 0, 1, 0, 0, 64'h0);  check("beq_bubble", de_v, 1'b0); tick;
        drive(1, 0, 1, 1, 1, 64'h2040); chk_fetch("beq_resolve", 0, 0); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("beq_taken", 1, 64'h2040); tick;
        drive(1, 0, 1, 1, 0, 64'h5550); chk_fetch("beq_nt_resolve", 0, 0); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("beq_not_taken", 1, 64'h2044); tick;
        drive(1, 0, 1, 1, 1, 64'h3000); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("jal_fetch", 1, 64'h3000); tick;
`ifdef FE_JAL_REDIRECT_EN
        drive(1, 0, 1, 0, 0, 64'h0);  chk_fetch("jal_redirect", 1, 64'h3100); tick;
        drive(1, 0, 1, 0, 0, 64'h0);  chk_fetch("jal_target_held", 0, 0);
        check("jal_bubble", de_v, 1'b0); tick;
        drive(1, 0, 1, 1, 1, 64'h3100); chk_fetch("jal_resolve_ignored", 0, 0); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("jal_after", 1, 64'h3104);
        check("jal_tgt_dev", de_v, 1'b1); check("jal_tgt_npc", de_npc, 64'h3100); tick;
`else
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 64'h0); chk_fetch($sformatf("jal_wait%0d", i), 0, 0); tick;
        end
        drive(1, 0, 1, 1, 1, 64'h3100); chk_fetch("jal_resolve", 0, 0); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  chk_fetch("jal_target", 1, 64'h3100); tick;
        drive(1, 0, 0, 0, 0, 64'h0);  check("jal_tgt_npc", de_npc, 64'h3100);
        check("jal_tgt_dev", de_v, 1'b1); tick;
`endif
        // Reset while a request is waiting on memory; RDY in the reset cycle must be ignored.
        drive(0, 0, 0, 0, 0, 64'h0);  check("midreq_req", imem_req, 1'b1); tick;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 64'h0);  check("midreq_reset_req", imem_req, 1'b0); tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h0);  chk_fetch("midreq_after", 1, RST_PC);
        check("midreq_dev", de_v, 1'b0); tick;
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
        else t = 64'($urandom_range(0, 4095));
        return t;
    endfunction

    task automatic run_random;
        logic [31:0] tmp, w;
        logic [63:0] exp_addr, mdl_npc, tgt, pend_pc;
        logic [31:0] pend_ir;
        bit          exp_known, pending, stl_prev, brs_prev, mdl_v, rv, tk, brs, stl, rdy;
        int          delay, idle, r;
        for (int i = 0; i < 256; i++) begin
            tmp = $urandom();
            r   = $urandom_range(0, 19);
            if (r < 6)       rnd_mem[i] = {tmp[31:7], 7'h13};
            else if (r < 12) rnd_mem[i] = {tmp[31:7], 7'h33};
            else if (r < 15) rnd_mem[i] = {tmp[31:7], 7'h63};
            else if (r < 17) rnd_mem[i] = {tmp[31:7], 7'h67};
            else             rnd_mem[i] = {tmp[31:7], 7'h6F};
        end
        use_rnd = 1'b1;
        do_reset;
        exp_addr = RST_PC; exp_known = 1; pending = 0; stl_prev = 0; brs_prev = 0;
        mdl_v = 0; mdl_npc = '0; pend_pc = '0; pend_ir = '0; delay = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stl_prev) begin
                check("rnd_hold_v", de_v, mdl_v);
                if (mdl_v) begin
                    check("rnd_hold_npc", de_npc, mdl_npc);
                    check("rnd_hold_ir", de_ir, mem_word(mdl_npc));
                end
            end else if (de_v) begin
                idle = 0;
                checks++;
                if (brs_prev || !exp_known) begin
                    failures++;
                    $display("FAIL rnd_order: delivery of %h while a control transfer was unresolved", de_npc);
                    exp_addr = de_npc;
                end
                check("rnd_npc", de_npc, exp_addr);
                check("rnd_ir", de_ir, mem_word(exp_addr));
                mdl_v = 1; mdl_npc = exp_addr;
                w = mem_word(exp_addr);
                if (is_ctrl(w)) begin
                    pending = 1; delay = $urandom_range(1, 4);
                    pend_ir = w; pend_pc = exp_addr; exp_known = 0;
`ifdef FE_JAL_REDIRECT_EN
                    if (w[6:2] == 5'b11011) begin
                        exp_addr  = (pend_pc + jimm(w)) & ~64'h3;
                        exp_known = 1;
                    end
`endif
                end else begin
                    exp_addr = exp_addr + 64'd4;
                end
            end else begin
                mdl_v = 0;
                idle++;
                if (idle == 200) begin
                    checks++; failures++;
                    $display("FAIL rnd_progress: no delivery for 200 cycles, expecting %h", exp_addr);
                    break;
                end
            end

            rv = 0; tk = 0; tgt = rand_target(); brs = pending;
            if (pending) begin
                if (delay == 0) begin
                    rv = 1;
                    case (pend_ir[6:2])
                        5'b11000: tk = 1'($urandom_range(0, 1));
                        5'b11001: tk = 1;
                        default: begin tk = 1; tgt = pend_pc + jimm(pend_ir); end
                    endcase
`ifdef FE_JAL_REDIRECT_EN
                    if (pend_ir[6:2] != 5'b11011) begin
                        exp_addr = tk ? (tgt & ~64'h3) : pend_pc + 64'd4; exp_known = 1;
                    end
`else
                    exp_addr = tk ? (tgt & ~64'h3) : pend_pc + 64'd4; exp_known = 1;
`endif
                    pending = 0;
                end else begin
                    delay--;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 3) == 0);
            drive(rdy, stl, brs, rv, tk, tgt);
            check("rnd_addr_align", imem_addr[1:0], 2'b00);
            stl_prev = stl; brs_prev = brs;
            tick;
        end
        use_rnd = 1'b0;
    endtask

    initial begin
        run_table;
        run_branches;
        run_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 64-bit RISC-V pipeline and the producer side of the fetch→decode interface. It owns the PC and issues single-outstanding requests to instruction memory. It presents one instruction per cycle on `DE_IR`/`DE_NPC`/`DE_V`. It honours decode's `stall` and `V_DE_FE_BR_STALL`, freezes fetch behind control-transfer instructions, and redirects on branch resolution from execute.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset.
- `CLK` input 1: single clock; all state updates on posedge.
- `RESET` input 1: reset, synchronous and active-high.
- `IMEM_REQ` output 1: fetch request valid.
- `IMEM_ADDR` output 64: fetch address. Always equals PC; bits [1:0] are always 0.
- `IMEM_RDY` input 1: request completes in the cycle where `IMEM_REQ && IMEM_RDY`.
- `IMEM_DATA` input 32: instruction word, valid in the completion cycle.
- `stall` input 1: decode hold. While 1, decode does not consume `DE_*`.
- `V_DE_FE_BR_STALL` input 1: decode holds a valid control-transfer instruction (opcode[6:2] = 11000, 11001 or 11011).
- `BR_RESOLVE_V` input 1: one-cycle pulse from execute when a control-transfer instruction resolves.
- `BR_TAKEN` input 1: redirect required. It is 1 for JAL and JALR.
- `BR_TARGET` input 64: redirect address.
- `DE_IR` output 32: instruction to decode.
- `DE_NPC` output 64: address of the instruction in `DE_IR`.
- `DE_V` output 1: `DE_IR`/`DE_NPC` hold a valid instruction.

## Operation
States:
- **FETCH**: `IMEM_REQ = !RESET`.
- **HOLD**: a fetched word is parked in a one-entry buffer (`buf_ir`, `buf_pc`). `IMEM_REQ = 0`.
- **BR_WAIT**: fetch is frozen behind a control-transfer instruction. `IMEM_REQ = 0`.

Definitions:
- `ctrl(w)`: `w[6:2]` ∈ {11000, 11001, 11011}.
- `avail`: the word available this cycle. It is the buffer in HOLD, or `IMEM_DATA` on completion in FETCH.
- `deliver = avail && !stall && !V_DE_FE_BR_STALL`.

DE register update each cycle:
- `stall = 1`: `DE_*` hold their values.
- Else, if `deliver`: `DE_IR <= word`, `DE_NPC <= its address`, `DE_V <= 1`.
- Else: `DE_V <= 0` (bubble). `DE_IR`/`DE_NPC` are don't-care.

State transitions:
- **FETCH**, on completion:
  - PC <= PC + 4.
  - If `deliver`: go to BR_WAIT if ctrl(word), else stay in FETCH (next request issues the following cycle).
  - If not `deliver`: capture the word and its address into the buffer and go to HOLD.
- **FETCH**, with no completion: stay in FETCH.
- **HOLD**: on `deliver`, go to BR_WAIT if ctrl(buf_ir), else go to FETCH.
- **BR_WAIT**: on `BR_RESOLVE_V`:
  - If `BR_TAKEN`: PC <= {BR_TARGET[63:2], 2'b00}. Otherwise PC is unchanged (already the sequential address).
  - Go to FETCH.
- `BR_RESOLVE_V` is ignored outside BR_WAIT.

Arithmetic: PC + 4 is 64-bit and wraps modulo 2^64 without a flag.

Reset:
- On reset: PC <= RESET_PC, state <= FETCH, `DE_V <= 0`, buffer invalid.
- `IMEM_RDY` in the reset cycle is ignored.
- Reset mid-request abandons the request, and `IMEM_REQ` is 0 during the reset cycle. Instruction memory drops any request that is deasserted before completion.

Simultaneous events:
- `stall` and `V_DE_FE_BR_STALL` both 1: `stall` wins and DE holds.
- Completion while `stall = 1`: the word goes to the buffer. It is never lost and never duplicated.

## Timing
- Zero-wait memory (`IMEM_RDY` tied 1) with no stalls: one instruction per cycle. `DE_V` is 1 from the cycle after the first completion.
- Request to DE: `DE_*` updates at the posedge that ends the completion cycle. Latency is one cycle plus memory wait states.
- Buffered word to DE: updates at the first edge where `deliver` is true.
- Control transfer: the cycle after `BR_RESOLVE_V`, `IMEM_REQ = 1` with the new `IMEM_ADDR`.
- Minimum penalty is 1 bubble per control-transfer instruction, plus the resolution delay.
- Outputs are registered, except `IMEM_REQ` and `IMEM_ADDR`, which decode from state, PC and `RESET`.

## Configuration
- `FE_JAL_REDIRECT_EN` defined:
  - When a JAL (opcode[6:2] = 11011) is delivered, PC <= DE_NPC_new + J-immediate (`{{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}`).
  - State goes to FETCH instead of BR_WAIT.
  - Execute's later `BR_RESOLVE_V` for that JAL is ignored.
  - The target word still waits for `V_DE_FE_BR_STALL = 0` before delivery.
- Undefined: JAL is handled like BRANCH and JALR, entering BR_WAIT.

## Test plan
- **Reset and sequential fetch.** `RESET_PC = 64'h1000`, RDY = 1, NOPs, no stalls → `IMEM_ADDR` 1000, 1004, 1008, … in consecutive cycles; `DE_V = 1` from the second cycle; `DE_NPC` tracks the fetched address.
- **Stall.** Stall for 3 cycles with a completion at 1010 → `DE_*` frozen for 3 cycles; word 1010 held in HOLD with REQ = 0; delivered exactly once after stall drops; next request is 1014.
- **Taken branch.** BEQ at 2000 delivered → REQ = 0; `DE_V = 0` each cycle; then `BR_RESOLVE_V = 1`, `BR_TAKEN = 1`, `BR_TARGET = 2040` → next-cycle `IMEM_ADDR = 2040`.
- **Not-taken branch.** Same as above with `BR_TAKEN = 0` → next `IMEM_ADDR = 2004`.
- **JAL.** JAL with offset +0x100 at 3000:
  - With `FE_JAL_REDIRECT_EN`: next request 3100 with no wait for `BR_RESOLVE_V`.
  - Without it: REQ stays 0 until `BR_RESOLVE_V`.
- **Reset mid-request.** RDY held 0, `RESET` asserted mid-request → REQ = 0 in the reset cycle; `DE_V = 0`; next cycle `IMEM_ADDR = RESET_PC`.
